udp_frame_write_ctrl: RTL
=========================

# udp_frame_write_ctrl

Write controller between the UDP RGB16 pixel parser and the frame-buffer memory port. It accepts parser pixels, repacks them to RGB565, and buffers them in a small FIFO. It sequences them as addressed single-word write requests with a req/ack handshake, using a linear raster address that wraps per frame. Frame-start resync and overflow reporting are included.

## Interface
- IMG_W, 800, pixels per line
- IMG_H, 600, lines per frame
- ADDR_W, 20, write address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, ≥2)

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  when low, incoming pixels are ignored; queued pixels still drain
- i_frame_start  in  1  one-cycle pulse: resync to pixel 0 of a new frame
- i_pix_valid  in  1  one-cycle pixel strobe from parser
- i_pix_R / i_pix_G / i_pix_B  in  8 each  channel values
- o_wr_req  out  1  write request
- o_wr_addr  out  ADDR_W  linear pixel address (y·IMG_W + x)
- o_wr_data  out  16  {R[7:3], G[7:2], B[7:3]}
- i_wr_ack  in  1  memory accepts current request this cycle
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is acked
- o_overflow  out  1  sticky: a pixel was dropped on a full FIFO
- o_busy  out  1  FIFO non-empty or request outstanding

## Operation
- Push: a pixel is pushed when i_pix_valid & i_enable & FIFO not full, and is stored as repacked RGB565.
- Drop on full: when i_pix_valid & i_enable & FIFO full, the pixel is discarded and o_overflow is set.
- FSM has two states:
  - S_IDLE: if the FIFO is non-empty, pop the head, load o_wr_data and o_wr_addr = addr counter, and go to S_REQ.
  - S_REQ: o_wr_req = 1, with address and data held stable until i_wr_ack.
    - On ack with FIFO non-empty: pop the next word and stay in S_REQ (back-to-back).
    - On ack with FIFO empty: go to S_IDLE.
- Address counter advances by 1 on each ack.
  - On the ack of address IMG_W·IMG_H−1, the counter wraps to 0 and o_frame_done pulses.
- i_frame_start:
  - The FIFO is flushed and o_overflow is cleared.
  - An outstanding request completes at its loaded address; its ack does not advance the counter and does not pulse o_frame_done.
  - The address counter is forced to 0.
  - A pixel arriving in the same cycle as i_frame_start is kept, becoming the sole FIFO entry (address 0).
- i_wr_ack while o_wr_req = 0 is ignored.
- Reset mid-operation aborts any request immediately; no ack is awaited.

## Timing
- Reset values: o_wr_req 0, o_wr_addr 0, o_wr_data 0, o_frame_done 0, o_overflow 0, o_busy 0; FIFO empty; state S_IDLE.
- Latency: a pixel strobed in cycle N into an empty, idle controller gives o_wr_req = 1 in cycle N+2.
  - N+1: FIFO registered.
  - N+2: request registered.
- Throughput: one write per cycle while ack is held high and the FIFO is non-empty.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds and nothing is dropped.
- o_frame_done is asserted in the cycle after the final ack.
- o_busy is combinational from FIFO count and state.

## Configuration
- FRAME_WRITE_STATS_EN:
  - Defined: adds outputs o_drop_cnt[15:0] and o_frame_cnt[15:0], both reset to 0.
    - o_drop_cnt increments per dropped pixel and saturates at 0xFFFF.
    - o_frame_cnt increments per o_frame_done and wraps.
    - Neither counter is cleared by i_frame_start.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Single pixel (R=0xF8, G=0xFC, B=0xF8), ack held high → one request, addr 0, data 0xFFFF, o_wr_req high exactly 1 cycle, o_busy low afterwards.
- Back-to-back: 5 pixels pushed 1 per cycle, ack tied 1 → five consecutive req cycles, addresses 0..4, no idle gap.
- Backpressure: ack held 0 while FIFO_DEPTH+3 pixels arrive (=19 at FIFO_DEPTH=16).
  - o_overflow = 1; addr/data stable throughout.
  - After releasing ack, exactly 17 writes occur (FIFO_DEPTH plus the one loaded into S_REQ); with stats enabled, o_drop_cnt = 2.
- Frame wrap with IMG_W=4, IMG_H=2, 9 pixels, immediate ack → addresses 0..7 then 0; o_frame_done pulses once, the cycle after addr 7's ack.
- i_frame_start while a request at addr 3 is pending, with a pixel in the same cycle and 2 older pixels queued.
  - The pending write completes at addr 3.
  - The older pixels are discarded.
  - The next write goes to addr 0 with the new pixel; o_overflow is cleared.
- Asynchronous reset asserted with o_wr_req high → all outputs 0 immediately; after release, no spurious request.

Source files
------------

// File: rtl/udp_frame_write_ctrl.sv
// Frame-buffer write sequencer: repacks parser pixels to RGB565, queues them, and issues req/ack writes on a raster address.
// Optional FRAME_WRITE_STATS_EN adds the o_drop_cnt / o_frame_cnt statistics outputs.
module udp_frame_write_ctrl #(
    parameter int IMG_W      = 800,
    parameter int IMG_H      = 600,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_frame_start,
    input  logic              i_pix_valid,
    input  logic [7:0]        i_pix_R,
    input  logic [7:0]        i_pix_G,
    input  logic [7:0]        i_pix_B,
    output logic              o_wr_req,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    input  logic              i_wr_ack,
    output logic              o_frame_done,
    output logic              o_overflow,
`ifdef FRAME_WRITE_STATS_EN
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_frame_cnt,
`endif
    output logic              o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            r_state;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_addrCnt;
    logic              r_stale;

    logic              w_pixIn;
    logic              w_full;
    logic              w_ackTake;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_lastAck;
    logic [15:0]       w_pixData;
    logic [15:0]       w_headData;
    logic [PTR_W-1:0]  w_wrIdx;
    logic [ADDR_W-1:0] w_addrNext;
    logic              w_unusedBits;

    assign w_pixData    = {i_pix_R[7:3], i_pix_G[7:2], i_pix_B[7:3]};
    assign w_unusedBits = ^{i_pix_R[2:0], i_pix_G[1:0], i_pix_B[2:0]};
    assign w_headData   = r_mem[r_rdPtr];
    assign w_full       = (r_count == FULL_CNT);
    assign w_pixIn      = i_pix_valid & i_enable;
    assign w_ackTake    = (r_state == S_REQ) & i_wr_ack;
    // A frame-start flush discards the old queue, so nothing is popped from it in that cycle.
    assign w_pop        = ~i_frame_start & (r_count != '0) & ((r_state == S_IDLE) | i_wr_ack);
    assign w_push       = w_pixIn & (i_frame_start | ~w_full | w_pop);
    assign w_drop       = w_pixIn & ~i_frame_start & w_full & ~w_pop;
    assign w_wrIdx      = i_frame_start ? '0 : r_wrPtr;
    assign w_lastAck    = w_ackTake & ~r_stale & (r_addrCnt == LAST_ADDR);
    // A request left over from before a frame start must not move the freshly zeroed counter.
    assign w_addrNext   = r_stale ? r_addrCnt :
                          ((r_addrCnt == LAST_ADDR) ? '0 : r_addrCnt + 1'b1);
    assign o_busy       = (r_count != '0) | (r_state == S_REQ);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[w_wrIdx] <= w_pixData;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_frame_start) begin
            r_rdPtr <= '0;
            r_wrPtr <= PTR_W'(w_push);
            r_count <= (PTR_W + 1)'(w_push);
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            o_wr_req     <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
            r_addrCnt    <= '0;
            r_stale      <= 1'b0;
        end else begin
            o_frame_done <= w_lastAck;

            if (i_frame_start)  o_overflow <= 1'b0;
            else if (w_drop)    o_overflow <= 1'b1;

            if (i_frame_start)  r_addrCnt <= '0;
            else if (w_ackTake) r_addrCnt <= w_addrNext;

            if (w_ackTake)                              r_stale <= 1'b0;
            else if (i_frame_start && r_state == S_REQ) r_stale <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_REQ;
                        o_wr_req  <= 1'b1;
                        o_wr_addr <= r_addrCnt;
                        o_wr_data <= w_headData;
                    end
                end
                S_REQ: begin
                    if (i_wr_ack) begin
                        if (w_pop) begin
                            o_wr_addr <= w_addrNext;
                            o_wr_data <= w_headData;
                        end else begin
                            r_state  <= S_IDLE;
                            o_wr_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    o_wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_WRITE_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt  <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (w_drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
            if (w_lastAck) o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end
`endif

endmodule
